// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//
// Bundles the control inputs and PC outputs of pc_sequencer so that the
// fetch stage and the decode/execute control can share one connection.
//
// Parameter:
//   PC_W     program-counter width; must match the PC_W of the sequencer
//            that uses this interface.
//
// Signals:
//   stall    hold the PC this cycle
//   PCSel    next-PC select (seq/branch/jump/jr/reload/trap/eret)
//   bne      branch sense: 0 = beq, 1 = bne
//   zero     ALU zero flag
//   imm      sign-extended branch word offset
//   jtarget  instruction bits [25:0] for j/jal
//   jrPC     register jump target
//   link     jal/jalr marker (return-address stack builds only)
//   PC       current program counter
//   PCPlus4  PC + 4
//   PCValid  PC is a real fetch address
//   EPC      exception PC
//
// Modports:
//   master   control side, drives the selects and sees the PC
//   slave    the sequencer itself
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic [2:0]      PCSel;
    logic            bne;
    logic            zero;
    logic [31:0]     imm;
    logic [25:0]     jtarget;
    logic [PC_W-1:0] jrPC;
    logic            link;

    logic [PC_W-1:0] PC;
    logic [PC_W-1:0] PCPlus4;
    logic            PCValid;
    logic [PC_W-1:0] EPC;

    modport master (
        output stall, PCSel, bne, zero, imm, jtarget, jrPC, link,
        input  PC, PCPlus4, PCValid, EPC
    );

    modport slave (
        input  stall, PCSel, bne, zero, imm, jtarget, jrPC, link,
        output PC, PCPlus4, PCValid, EPC
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the pipelined datapath. Holds the PC and
// picks the next PC from sequential, branch, jump, jump-register,
// reset-vector reload, trap and exception-return sources. A one-entry
// pending buffer remembers a redirect requested while the pipe is stalled
// and applies it on the first non-stalled edge. An EPC register records the
// PC of the trapping instruction for the later eret.
//
// Ports:
//   CLK      clock, rising edge
//   RSTn     asynchronous active-low reset
//   seq      pc_sequencer_if.slave: stall, PCSel, bne, zero, imm, jtarget,
//            jrPC, link in; PC, PCPlus4, PCValid, EPC out
//
// Parameters:
//   PC_W          PC width, 28..32
//   RESET_VECTOR  PC after reset and on PCSel = 100
//   TRAP_VECTOR   PC loaded on a trap
//   RAS_DEPTH     return-address-stack entries (PC_RAS_EN builds only)
//
// Build option:
//   PC_RAS_EN  when defined, adds a circular return-address stack. jal/jalr
//              (link=1 with PCSel 010/011) push PC+4; jr with link=0 pops
//              the top entry and uses it instead of jrPC when the stack is
//              not empty. Without it, link is ignored and jr uses jrPC.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int          PC_W         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int          RAS_DEPTH    = 4
) (
    input logic           CLK,
    input logic           RSTn,
    pc_sequencer_if.slave seq
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_PEND = 2'b10;

    localparam logic [2:0] SEL_SEQ    = 3'b000;
    localparam logic [2:0] SEL_BRANCH = 3'b001;
    localparam logic [2:0] SEL_JUMP   = 3'b010;
    localparam logic [2:0] SEL_JR     = 3'b011;
    localparam logic [2:0] SEL_RELOAD = 3'b100;
    localparam logic [2:0] SEL_TRAP   = 3'b101;
    localparam logic [2:0] SEL_ERET   = 3'b110;

    localparam logic [PC_W-1:0] RESET_PC = RESET_VECTOR[PC_W-1:0];
    localparam logic [PC_W-1:0] TRAP_PC  = TRAP_VECTOR[PC_W-1:0];
    localparam logic [PC_W-1:0] FOUR     = PC_W'(4);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]      state_reg, state_next;
    logic [PC_W-1:0] pc_reg,    pc_next;
    logic [PC_W-1:0] epc_reg,   epc_next;
    logic [PC_W-1:0] pend_reg,  pend_next;

    // -----------------------------------------------------------------------
    // Target arithmetic (all modulo 2^PC_W)
    // -----------------------------------------------------------------------
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] jr_target;
    logic [PC_W-1:0] target;
    logic            taken;
    logic            redirect;
    logic            is_trap;
    logic            update_edge;

    // imm is 32 bits wide regardless of PC_W; only the low PC_W bits
    // survive the truncation, so fold it into a sink to keep lint quiet
    // for narrow builds.
    logic            unused_imm;
    assign unused_imm = ^seq.imm;

    assign pc_plus4      = pc_reg + FOUR;
    assign branch_target = pc_plus4 + {seq.imm[PC_W-3:0], 2'b00};

    // The region bits above the 28-bit jump field only exist when PC_W > 28.
    generate
        if (PC_W > 28) begin : g_jump_region
            assign jump_target = {pc_plus4[PC_W-1:28], seq.jtarget, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {seq.jtarget, 2'b00};
        end
    endgenerate

    assign taken = seq.bne ? ~seq.zero : seq.zero;

    // The PC only consumes PCSel on a non-stalled RUN edge; this is also the
    // only edge on which the return-address stack may move.
    assign update_edge = (state_reg == ST_RUN) && !seq.stall;

    assign is_trap = (seq.PCSel == SEL_TRAP);

`ifdef PC_RAS_EN
    // -----------------------------------------------------------------------
    // Return-address stack: circular buffer with a write pointer to the next
    // free slot and a saturating occupancy count. When full, a push wraps
    // onto the oldest entry.
    // -----------------------------------------------------------------------
    localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_wptr_reg,  ras_wptr_next;
    logic [RAS_CW-1:0] ras_count_reg, ras_count_next;
    logic [RAS_AW-1:0] ras_top_idx;
    logic [RAS_AW-1:0] ras_wptr_inc;
    logic              ras_push;
    logic              ras_pop;

    assign ras_top_idx  = (ras_wptr_reg == '0) ? RAS_AW'(RAS_DEPTH - 1)
                                               : ras_wptr_reg - RAS_AW'(1);
    assign ras_wptr_inc = (ras_wptr_reg == RAS_AW'(RAS_DEPTH - 1)) ? '0
                                               : ras_wptr_reg + RAS_AW'(1);

    assign ras_push = update_edge && seq.link &&
                      ((seq.PCSel == SEL_JUMP) || (seq.PCSel == SEL_JR));
    assign ras_pop  = update_edge && !seq.link &&
                      (seq.PCSel == SEL_JR) && (ras_count_reg != '0);

    assign jr_target = ras_pop ? ras_mem[ras_top_idx] : seq.jrPC;

    always_comb begin
        ras_wptr_next  = ras_wptr_reg;
        ras_count_next = ras_count_reg;
        if (ras_push) begin
            ras_wptr_next = ras_wptr_inc;
            if (ras_count_reg != RAS_CW'(RAS_DEPTH)) begin
                ras_count_next = ras_count_reg + RAS_CW'(1);
            end
        end else if (ras_pop) begin
            ras_wptr_next  = ras_top_idx;
            ras_count_next = ras_count_reg - RAS_CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ras_wptr_reg  <= '0;
            ras_count_reg <= '0;
        end else begin
            ras_wptr_reg  <= ras_wptr_next;
            ras_count_reg <= ras_count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_entry
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    ras_mem[gi] <= '0;
                end else if (ras_push && (ras_wptr_reg == RAS_AW'(gi))) begin
                    ras_mem[gi] <= pc_plus4;
                end
            end
        end
    endgenerate
`else
    // No return-address stack: jr always follows the register value and the
    // link marker has no effect.
    logic unused_link;
    assign unused_link = seq.link;
    assign jr_target   = seq.jrPC;
`endif

    // -----------------------------------------------------------------------
    // Next-target select
    // -----------------------------------------------------------------------
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b1;
        case (seq.PCSel)
            SEL_BRANCH: begin
                target   = taken ? branch_target : pc_plus4;
                redirect = taken;
            end
            SEL_JUMP:   target = jump_target;
            SEL_JR:     target = jr_target;
            SEL_RELOAD: target = RESET_PC;
            SEL_TRAP:   target = TRAP_PC;
            SEL_ERET:   target = epc_reg;
            default: begin
                // 000 and 111 are both plain sequential fetch.
                target   = pc_plus4;
                redirect = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        pend_next  = pend_reg;
        case (state_reg)
            ST_INIT: begin
                // First cycle out of reset: inputs are not yet meaningful.
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!seq.stall) begin
                    pc_next = target;
                    if (is_trap) begin
                        epc_next = pc_reg;
                    end
                end else if (redirect) begin
                    // Park the redirect; PC stays put until the stall ends.
                    pend_next  = target;
                    state_next = ST_PEND;
                    if (is_trap) begin
                        epc_next = pc_reg;
                    end
                end
            end
            ST_PEND: begin
                if (seq.stall) begin
                    // Latest redirect wins while still stalled.
                    if (redirect) begin
                        pend_next = target;
                        if (is_trap) begin
                            epc_next = pc_reg;
                        end
                    end
                end else begin
                    // The parked redirect takes priority over PCSel now.
                    pc_next    = pend_reg;
                    pend_next  = '0;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_INIT;
                pc_next    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= ST_INIT;
            pc_reg    <= RESET_PC;
            epc_reg   <= '0;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            pend_reg  <= pend_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign seq.PC      = pc_reg;
    assign seq.PCPlus4 = pc_plus4;
    assign seq.PCValid = (state_reg == ST_RUN) || (state_reg == ST_PEND);
    assign seq.EPC     = epc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed-vector bench for pc_sequencer. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, well clear of the edge.
// Define PC_RAS_EN for both DUT and bench to include the stack sequence.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    pc_sequencer_if #(.PC_W(32)) bus ();

    pc_sequencer #(
        .PC_W        (32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0080),
        .RAS_DEPTH   (4)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .seq (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall   = 1'b0;
        bus.PCSel   = 3'b000;
        bus.bne     = 1'b0;
        bus.zero    = 1'b0;
        bus.imm     = 32'h0;
        bus.jtarget = 26'h0;
        bus.jrPC    = 32'h0;
        bus.link    = 1'b0;
    endtask

    // Set the PC through a plain jr and confirm it landed.
    task automatic go_to(input logic [31:0] addr, input string tag);
        idle_inputs();
        bus.PCSel = 3'b011;
        bus.jrPC  = addr;
        step();
        check_val(tag, bus.PC, addr);
        idle_inputs();
    endtask

    // One unstalled edge with the given select, then check the PC.
    task automatic sel_step(input logic [2:0] sel, input string tag,
                            input logic [31:0] exp_pc);
        bus.stall = 1'b0;
        bus.PCSel = sel;
        step();
        check_val(tag, bus.PC, exp_pc);
    endtask

`ifdef PC_RAS_EN
    logic [31:0] jal_dest [5];
    logic [31:0] ret_addr [5];
`endif

    initial begin
        idle_inputs();

        // ---------------- reset ----------------
        #1;
        check_val("rst_pc",    bus.PC, 32'h0);
        check_val("rst_valid", 32'(bus.PCValid), 32'h0);
        check_val("rst_epc",   bus.EPC, 32'h0);
        step();
        step();
        check_val("rst_hold_pc", bus.PC, 32'h0);
        RSTn = 1'b1;
        #2;
        check_val("init_valid", 32'(bus.PCValid), 32'h0);
        check_val("init_plus4", bus.PCPlus4, 32'h4);
        step();
        check_val("run_pc0",    bus.PC, 32'h0);
        check_val("run_valid",  32'(bus.PCValid), 32'h1);
        sel_step(3'b000, "seq_4", 32'h4);
        sel_step(3'b000, "seq_8", 32'h8);

        // ---------------- branches ----------------
        go_to(32'h4, "goto_4a");
        bus.imm = 32'd10; bus.bne = 1'b0; bus.zero = 1'b1;
        sel_step(3'b001, "beq_taken", 32'h30);
        go_to(32'h4, "goto_4b");
        bus.imm = 32'd10; bus.bne = 1'b0; bus.zero = 1'b0;
        sel_step(3'b001, "beq_not_taken", 32'h8);
        go_to(32'h4, "goto_4c");
        bus.imm = 32'd10; bus.bne = 1'b1; bus.zero = 1'b0;
        sel_step(3'b001, "bne_taken", 32'h30);
        go_to(32'h4, "goto_4d");
        bus.imm = 32'd10; bus.bne = 1'b1; bus.zero = 1'b1;
        sel_step(3'b001, "bne_not_taken", 32'h8);
        go_to(32'h30, "goto_30");
        bus.imm = 32'hFFFF_FFFC; bus.bne = 1'b0; bus.zero = 1'b1;
        sel_step(3'b001, "beq_backward", 32'h24);

        // ---------------- jump / jr ----------------
        go_to(32'h0, "goto_0");
        idle_inputs();
        bus.jtarget = 26'h010_0014;
        sel_step(3'b010, "jump", 32'h0040_0050);
        idle_inputs();
        bus.jrPC = 32'hC;
        sel_step(3'b011, "jr", 32'hC);
        idle_inputs();
        sel_step(3'b111, "sel111_seq", 32'h10);

        // ---------------- stall with buffered redirect ----------------
        idle_inputs();
        bus.stall = 1'b1; bus.PCSel = 3'b010; bus.jtarget = 26'h000_0100;
        step();
        check_val("stall1_pc", bus.PC, 32'h10);
        bus.stall = 1'b1; bus.PCSel = 3'b011; bus.jrPC = 32'h40;
        step();
        check_val("stall2_pc", bus.PC, 32'h10);
        bus.stall = 1'b1; bus.PCSel = 3'b000;
        step();
        check_val("stall3_pc",    bus.PC, 32'h10);
        check_val("stall3_valid", 32'(bus.PCValid), 32'h1);
        bus.stall = 1'b0; bus.PCSel = 3'b010; bus.jtarget = 26'h000_0200;
        step();
        check_val("pend_release", bus.PC, 32'h40);
        idle_inputs();
        sel_step(3'b000, "after_pend_seq", 32'h44);

        // stall with no redirect just holds
        bus.stall = 1'b1; bus.PCSel = 3'b000;
        step();
        check_val("plain_stall", bus.PC, 32'h44);
        sel_step(3'b000, "plain_release", 32'h48);

        // ---------------- trap / eret / reload ----------------
        go_to(32'h24, "goto_24");
        sel_step(3'b101, "trap_pc", 32'h80);
        check_val("trap_epc", bus.EPC, 32'h24);
        sel_step(3'b000, "trap_seq1", 32'h84);
        sel_step(3'b000, "trap_seq2", 32'h88);
        sel_step(3'b110, "eret_pc", 32'h24);
        sel_step(3'b100, "reload_pc", 32'h0);
        check_val("reload_epc",   bus.EPC, 32'h24);
        check_val("reload_valid", 32'(bus.PCValid), 32'h1);
        sel_step(3'b000, "reload_seq", 32'h4);

        // trap parked during a stall captures EPC at latch time
        bus.stall = 1'b1; bus.PCSel = 3'b101;
        step();
        check_val("stall_trap_pc",  bus.PC, 32'h4);
        check_val("stall_trap_epc", bus.EPC, 32'h4);
        idle_inputs();
        sel_step(3'b000, "stall_trap_release", 32'h80);

`ifdef PC_RAS_EN
        // ---------------- return-address stack ----------------
        jal_dest[0] = 32'h1000; jal_dest[1] = 32'h1100; jal_dest[2] = 32'h1200;
        jal_dest[3] = 32'h1300; jal_dest[4] = 32'h1400;
        // Newest first; 0x204 was overwritten, last pop falls back to jrPC.
        ret_addr[0] = 32'h1304; ret_addr[1] = 32'h1204; ret_addr[2] = 32'h1104;
        ret_addr[3] = 32'h1004; ret_addr[4] = 32'h0100;
        go_to(32'h200, "ras_goto_200");
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            bus.link    = 1'b1;
            bus.jtarget = 26'(jal_dest[i] >> 2);
            sel_step(3'b010, $sformatf("ras_jal%0d", i), jal_dest[i]);
        end
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            bus.jrPC = 32'h100;
            sel_step(3'b011, $sformatf("ras_pop%0d", i), ret_addr[i]);
        end
`endif

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the single-cycle PC control unit. Holds the program counter and selects the next PC from sequential, branch, jump, jump-register, reset-reload, trap and exception-return sources. Adds what the single-cycle unit lacks:
- a stall input for the pipelined datapath;
- a one-entry pending-redirect buffer, so redirects issued during a stall are not lost;
- an EPC register for traps.

Sits between the fetch stage (drives instruction memory address) and the decode/execute control.

Parameters:
PC_W, 32, PC width in bits; legal range 28..32.
RESET_VECTOR, 32'h0000_0000, PC value after reset and on PCSel=100.
TRAP_VECTOR, 32'h0000_0080, PC value loaded on trap.
RAS_DEPTH, 4, return-address-stack entries; only used with PC_RAS_EN.

Ports:
CLK  in  1  clock, rising edge.
RSTn  in  1  asynchronous active-low reset.
stall  in  1  hold PC this cycle.
PCSel  in  3  next-PC select: 000 seq, 001 branch, 010 jump, 011 jr, 100 reload reset vector, 101 trap, 110 eret, 111 treated as 000.
bne  in  1  branch sense: 0 = beq (taken if zero), 1 = bne (taken if !zero).
zero  in  1  ALU zero flag.
imm  in  32  sign-extended branch word offset.
jtarget  in  26  instruction bits [25:0].
jrPC  in  PC_W  register jump target.
link  in  1  jal/jalr marker; used only with PC_RAS_EN.
PC  out  PC_W  current PC.
PCPlus4  out  PC_W  PC+4, combinational from PC.
PCValid  out  1  PC is a real fetch address.
EPC  out  PC_W  exception PC.

Behaviour:
- Reset: RSTn low asynchronously forces PC=RESET_VECTOR, EPC=0, PCValid=0, pending buffer cleared, state=INIT.
- Arithmetic: all results are modulo 2^PC_W.
  - PCPlus4 = PC+4.
  - Branch target = PCPlus4 + (imm<<2), truncated to PC_W.
  - Jump target = {PCPlus4[PC_W-1:28], jtarget, 2'b00}.
- next_target:
  - 000/111: PCPlus4.
  - 001: branch target if taken, else PCPlus4.
  - 010: jump target.
  - 011: jrPC.
  - 100: RESET_VECTOR.
  - 101: TRAP_VECTOR.
  - 110: EPC.
- Redirect = any PCSel except 000/111, and except 001 not-taken.
- FSM states: INIT, RUN, PEND.
  - INIT: one cycle after RSTn rises. PC held at RESET_VECTOR, PCValid=0, all inputs ignored. Next state RUN, PCValid=1.
  - RUN, stall=0: PC <= next_target.
  - RUN, stall=1, no redirect: PC held.
  - RUN, stall=1, redirect: PC held, next_target latched into pending, go to PEND.
  - PEND, stall=1: PC held. A new redirect overwrites pending (latest wins).
  - PEND, stall=0: PC <= pending and PCSel is ignored that cycle; pending cleared; go to RUN.
- Trap (PCSel=101) with stall=0 in RUN: EPC <= current PC, same edge as the PC update. A trap latched into pending also captures EPC at latch time.
- Eret uses the EPC value present at that edge.
- PCSel=100 behaves as a normal redirect. It is not a reset: EPC is preserved and there is no INIT cycle.
- PCValid is 1 in RUN and PEND.
- Latency: redirect visible on PC one edge after the select, or one edge after stall drops if buffered.

Optional Feature:
Macro PC_RAS_EN.
- Defined:
  - Adds a RAS_DEPTH circular return-address stack.
  - Push PCPlus4 when link=1 and PCSel is 010 or 011 on an updating edge.
  - PCSel=011 with link=0 pops and uses the top entry instead of jrPC when the stack is non-empty.
  - When empty, jrPC is used and the pointer does not move.
  - Overflow overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Stalled edges neither push nor pop.
  - Reset empties the stack.
- Undefined: no stack; link is ignored; 011 always uses jrPC.

Test Plan:
- Reset, release RSTn, hold PCSel=000 -> PC=0 and PCValid=0 for one cycle; then PC=0x4, 0x8 on successive edges.
- PC=0x4, PCSel=001, imm=10, bne=0, zero=1 -> PC=0x30. With bne=0, zero=0 -> PC=0x8. With bne=1, zero=0 -> PC=0x30.
- PC=0x0, PCSel=010, jtarget=ins 0x08100014[25:0] -> PC=0x00400050. Then PCSel=011, jrPC=12 -> PC=0xC.
- PC=0x10, stall=1 for 3 cycles with PCSel=010 in cycle 1 and PCSel=011 (jrPC=0x40) in cycle 2 -> PC stays 0x10; on stall drop PC=0x40 regardless of the PCSel then applied.
- PC=0x24, PCSel=101 -> PC=0x80, EPC=0x24. Two seq cycles, then PCSel=110 -> PC=0x24.
- With PC_RAS_EN, RAS_DEPTH=4: five jal pushes, then five jr pops (jrPC=0x100) -> the four most recent return addresses in LIFO order, then 0x100.
